// File: rtl/am2901_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : am2901_pkg
//  Description : Shared microcode field encodings for the Am2901-style slice:
//                operand source (I2:0), ALU function (I5:3) and
//                destination/shift (I8:6).
//  Revision    : 1.0 - initial release
// ============================================================================
package am2901_pkg;

    localparam int SLICE_W = 4;
    localparam int RF_DEPTH = 16;
    localparam int RF_AW = 4;

    // Operand source pairs, named R then S
    typedef enum logic [2:0] {
        SRC_AQ = 3'd0,
        SRC_AB = 3'd1,
        SRC_ZQ = 3'd2,
        SRC_ZB = 3'd3,
        SRC_ZA = 3'd4,
        SRC_DA = 3'd5,
        SRC_DQ = 3'd6,
        SRC_DZ = 3'd7
    } src_e;

    // ALU functions; the first three are arithmetic, the rest are logic
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUBR  = 3'd1,
        OP_SUBS  = 3'd2,
        OP_OR    = 3'd3,
        OP_AND   = 3'd4,
        OP_NOTRS = 3'd5,
        OP_EXOR  = 3'd6,
        OP_EXNOR = 3'd7
    } op_e;

    // Destination / shift control
    typedef enum logic [2:0] {
        DST_QREG  = 3'd0,
        DST_NOP   = 3'd1,
        DST_RAMA  = 3'd2,
        DST_RAMF  = 3'd3,
        DST_RAMQD = 3'd4,
        DST_RAMD  = 3'd5,
        DST_RAMQU = 3'd6,
        DST_RAMU  = 3'd7
    } dest_e;

endpackage : am2901_pkg
`default_nettype wire

// File: rtl/am2901_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : am2901_regfile
//  Description : 16x4 register file with two asynchronous read ports, one
//                synchronous write port and an asynchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module am2901_regfile
    import am2901_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [RF_AW-1:0]   wr_addr,
    input  logic [SLICE_W-1:0] wr_data,
    input  logic [RF_AW-1:0]   rd_a_addr,
    input  logic [RF_AW-1:0]   rd_b_addr,
    output logic [SLICE_W-1:0] rd_a_data,
    output logic [SLICE_W-1:0] rd_b_data
);

    logic [SLICE_W-1:0] r_mem [RF_DEPTH];

    // Reads are unbypassed: a write only becomes visible after its edge
    assign rd_a_data = r_mem[rd_a_addr];
    assign rd_b_data = r_mem[rd_b_addr];

    // Storage update; clear takes priority over any write on the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

endmodule : am2901_regfile
`default_nettype wire

// File: rtl/am2901_slice.sv
`default_nettype none
// ============================================================================
//  Module      : am2901_slice
//  Description : 4-bit Am2901-equivalent bit-slice: register file, Q register,
//                operand selector, 8-function ALU and destination/shift logic.
//                Shift-in bits are tied to zero; there are no shift pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module am2901_slice
    import am2901_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [SLICE_W-1:0] din,
    input  logic [RF_AW-1:0]   a_addr,
    input  logic [RF_AW-1:0]   b_addr,
    input  logic [2:0]         src,
    input  logic [2:0]         op,
    input  logic [2:0]         dest,
    input  logic               cin,
    output logic [SLICE_W-1:0] yout,
    output logic               cout,
    output logic               f0,
    output logic               f3,
    output logic               ovr
);

    src_e               w_src;
    op_e                w_op;
    dest_e              w_dest;

    logic [SLICE_W-1:0] w_a;
    logic [SLICE_W-1:0] w_b;
    logic [SLICE_W-1:0] r_q;
    logic [SLICE_W-1:0] w_r;
    logic [SLICE_W-1:0] w_s;
    logic [SLICE_W-1:0] w_x;
    logic [SLICE_W-1:0] w_y;
    logic [SLICE_W:0]   w_sum;
    logic [3:0]         w_low;
    logic [SLICE_W-1:0] w_f;
    logic               w_cout;
    logic               w_ovr;
    logic               w_rf_we;
    logic [SLICE_W-1:0] w_rf_wdata;

    assign w_src  = src_e'(src);
    assign w_op   = op_e'(op);
    assign w_dest = dest_e'(dest);

    am2901_regfile u_regfile (
        .clock     (clock),
        .reset     (reset),
        .we        (w_rf_we),
        .wr_addr   (b_addr),
        .wr_data   (w_rf_wdata),
        .rd_a_addr (a_addr),
        .rd_b_addr (b_addr),
        .rd_a_data (w_a),
        .rd_b_data (w_b)
    );

    // Operand selection: R is A, D or zero; S is A, B, Q or zero
    always_comb begin
        w_r = '0;
        w_s = '0;
        case (w_src)
            SRC_AQ: begin w_r = w_a; w_s = r_q; end
            SRC_AB: begin w_r = w_a; w_s = w_b; end
            SRC_ZQ: begin w_r = '0;  w_s = r_q; end
            SRC_ZB: begin w_r = '0;  w_s = w_b; end
            SRC_ZA: begin w_r = '0;  w_s = w_a; end
            SRC_DA: begin w_r = din; w_s = w_a; end
            SRC_DQ: begin w_r = din; w_s = r_q; end
            SRC_DZ: begin w_r = din; w_s = '0;  end
            default: begin w_r = '0; w_s = '0; end
        endcase
    end

    // Subtractions are ones-complement additions; cin supplies the +1
    always_comb begin
        w_x = w_r;
        w_y = w_s;
        case (w_op)
            OP_SUBR: w_x = ~w_r;
            OP_SUBS: w_y = ~w_s;
            default: begin w_x = w_r; w_y = w_s; end
        endcase
    end

    // Full sum gives the carry out; the 3-bit partial sum gives carry into bit 3
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, cin};
    assign w_low = {1'b0, w_x[2:0]} + {1'b0, w_y[2:0]} + {3'b000, cin};

    // Function result and flags; logic ops force carry and overflow low
    always_comb begin
        w_f    = w_sum[SLICE_W-1:0];
        w_cout = 1'b0;
        w_ovr  = 1'b0;
        case (w_op)
            OP_ADD, OP_SUBR, OP_SUBS: begin
                w_f    = w_sum[SLICE_W-1:0];
                w_cout = w_sum[SLICE_W];
                w_ovr  = w_low[3] ^ w_sum[SLICE_W];
            end
            OP_OR:    w_f = w_r | w_s;
            OP_AND:   w_f = w_r & w_s;
            OP_NOTRS: w_f = ~w_r & w_s;
            OP_EXOR:  w_f = w_r ^ w_s;
            OP_EXNOR: w_f = ~(w_r ^ w_s);
            default:  w_f = w_sum[SLICE_W-1:0];
        endcase
    end

    assign cout = w_cout;
    assign ovr  = w_ovr;
    assign f0   = (w_f == '0);
    assign f3   = w_f[SLICE_W-1];
    assign yout = (w_dest == DST_RAMA) ? w_a : w_f;

    // Register-file write data: straight, shifted down or shifted up with zero fill
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_wdata = w_f;
        case (w_dest)
            DST_RAMA, DST_RAMF: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = w_f;
            end
            DST_RAMQD, DST_RAMD: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = {1'b0, w_f[SLICE_W-1:1]};
            end
            DST_RAMQU, DST_RAMU: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = {w_f[SLICE_W-2:0], 1'b0};
            end
            default: begin
                w_rf_we    = 1'b0;
                w_rf_wdata = w_f;
            end
        endcase
    end

    // Q register: load F, or shift alongside the register-file shift ops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            case (w_dest)
                DST_QREG:  r_q <= w_f;
                DST_RAMQD: r_q <= {1'b0, r_q[SLICE_W-1:1]};
                DST_RAMQU: r_q <= {r_q[SLICE_W-2:0], 1'b0};
                default:   r_q <= r_q;
            endcase
        end
    end

endmodule : am2901_slice
`default_nettype wire

// File: tb/tb_am2901_slice.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am2901_slice
//  Description : Directed self-checking bench for am2901_slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_am2901_slice;

    logic       clock;
    logic       reset;
    logic [3:0] din;
    logic [3:0] a_addr;
    logic [3:0] b_addr;
    logic [2:0] src;
    logic [2:0] op;
    logic [2:0] dest;
    logic       cin;
    logic [3:0] yout;
    logic       cout;
    logic       f0;
    logic       f3;
    logic       ovr;

    int checks;
    int failures;

    am2901_slice dut (
        .clock  (clock),
        .reset  (reset),
        .din    (din),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .src    (src),
        .op     (op),
        .dest   (dest),
        .cin    (cin),
        .yout   (yout),
        .cout   (cout),
        .f0     (f0),
        .f3     (f3),
        .ovr    (ovr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [2:0] o, input logic [2:0] d,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] dv,
                         input logic c);
        src = s; op = o; dest = d; a_addr = a; b_addr = b; din = dv; cin = c;
        #1;
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [3:0] val);
        drive(3'd7, 3'd0, 3'd3, 4'd0, addr, val, 1'b0);
        step();
    endtask

    task automatic load_q(input logic [3:0] val);
        drive(3'd7, 3'd0, 3'd0, 4'd0, 4'd0, val, 1'b0);
        step();
    endtask

    // Y = 0 + B with no write
    task automatic read_reg(input string tag, input logic [3:0] addr, input logic [3:0] exp);
        drive(3'd3, 3'd0, 3'd1, 4'd0, addr, 4'd0, 1'b0);
        check(tag, yout, exp);
    endtask

    // Y = 0 + Q with no write
    task automatic read_q(input string tag, input logic [3:0] exp);
        drive(3'd2, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        check(tag, yout, exp);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        src = 3'd1; op = 3'd0; dest = 3'd1; a_addr = 4'd0; b_addr = 4'd0;
        din = 4'd0; cin = 1'b0;
        #12;
        check("rst_y", yout, 4'h0);
        check("rst_f0", {3'b0, f0}, 4'h1);
        reset = 1'b0;
        #1;

        // D passes to Y before the edge, then reads back from reg2
        drive(3'd7, 3'd0, 3'd3, 4'd0, 4'd2, 4'h5, 1'b0);
        check("dz_y_pre", yout, 4'h5);
        step();
        read_reg("reg2_after", 4'd2, 4'h5);

        // ADD 5+3: signed overflow into negative
        write_reg(4'd1, 4'h5);
        write_reg(4'd2, 4'h3);
        drive(3'd1, 3'd0, 3'd1, 4'd1, 4'd2, 4'h0, 1'b0);
        check("add_y", yout, 4'h8);
        check("add_cout", {3'b0, cout}, 4'h0);
        check("add_f3", {3'b0, f3}, 4'h1);
        check("add_ovr", {3'b0, ovr}, 4'h1);
        check("add_f0", {3'b0, f0}, 4'h0);

        // SUBS 5-5 with cin=1
        write_reg(4'd2, 4'h5);
        drive(3'd1, 3'd2, 3'd1, 4'd1, 4'd2, 4'h0, 1'b1);
        check("subs_y", yout, 4'h0);
        check("subs_f0", {3'b0, f0}, 4'h1);
        check("subs_cout", {3'b0, cout}, 4'h1);
        check("subs_ovr", {3'b0, ovr}, 4'h0);
        drive(3'd1, 3'd7, 3'd1, 4'd1, 4'd2, 4'h0, 1'b1);
        check("exnor_y", yout, 4'hF);
        check("exnor_cout", {3'b0, cout}, 4'h0);

        // D=0xC, A=reg1=5: SUBR and logic functions
        drive(3'd5, 3'd1, 3'd1, 4'd1, 4'd0, 4'hC, 1'b1);
        check("subr_y", yout, 4'h9);
        check("subr_cout", {3'b0, cout}, 4'h0);
        check("subr_ovr", {3'b0, ovr}, 4'h1);
        drive(3'd5, 3'd3, 3'd1, 4'd1, 4'd0, 4'hC, 1'b1);
        check("or_y", yout, 4'hD);
        check("or_ovr", {3'b0, ovr}, 4'h0);
        drive(3'd5, 3'd4, 3'd1, 4'd1, 4'd0, 4'hC, 1'b0);
        check("and_y", yout, 4'h4);
        drive(3'd5, 3'd5, 3'd1, 4'd1, 4'd0, 4'hC, 1'b0);
        check("notrs_y", yout, 4'h1);
        drive(3'd5, 3'd6, 3'd1, 4'd1, 4'd0, 4'hC, 1'b0);
        check("exor_y", yout, 4'h9);

        // RAMA: Y shows A, reg3 gets F
        drive(3'd7, 3'd0, 3'd2, 4'd1, 4'd3, 4'hB, 1'b0);
        check("rama_y", yout, 4'h5);
        step();
        read_reg("rama_reg3", 4'd3, 4'hB);
        // RAMD: reg3 gets F>>1
        drive(3'd7, 3'd0, 3'd5, 4'd1, 4'd3, 4'hB, 1'b0);
        check("ramd_y", yout, 4'hB);
        step();
        read_reg("ramd_reg3", 4'd3, 4'h5);

        // RAMQU with Q=9, F=3
        load_q(4'h9);
        read_q("qreg_q", 4'h9);
        drive(3'd7, 3'd0, 3'd6, 4'd0, 4'd4, 4'h3, 1'b0);
        step();
        read_reg("ramqu_reg4", 4'd4, 4'h6);
        read_q("ramqu_q", 4'h2);
        // RAMQD with Q=9, F=3
        load_q(4'h9);
        drive(3'd7, 3'd0, 3'd4, 4'd0, 4'd4, 4'h3, 1'b0);
        step();
        read_reg("ramqd_reg4", 4'd4, 4'h1);
        read_q("ramqd_q", 4'h4);
        // RAMU: reg5 gets F<<1, Q untouched
        drive(3'd7, 3'd0, 3'd7, 4'd0, 4'd5, 4'hB, 1'b0);
        step();
        read_reg("ramu_reg5", 4'd5, 4'h6);
        read_q("ramu_q", 4'h4);

        // Asynchronous reset mid-cycle clears reg7 and Q immediately
        write_reg(4'd7, 4'hF);
        load_q(4'hF);
        drive(3'd0, 3'd3, 3'd1, 4'd7, 4'd0, 4'h0, 1'b0);
        check("pre_rst_y", yout, 4'hF);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_y", yout, 4'h0);
        // A write requested on an edge while reset is held must not land
        drive(3'd7, 3'd0, 3'd3, 4'd0, 4'd7, 4'hF, 1'b0);
        check("rst_comb_y", yout, 4'hF);
        step();
        drive(3'd7, 3'd0, 3'd0, 4'd0, 4'd7, 4'hF, 1'b0);
        step();
        drive(3'd3, 3'd0, 3'd1, 4'd0, 4'd7, 4'h0, 1'b0);
        reset = 1'b0;
        #1;
        read_reg("rst_reg7", 4'd7, 4'h0);
        read_q("rst_q", 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_am2901_slice
`default_nettype wire
